// File: rtl/parallel_dev_bridge.sv
// Bridge from the internal slave bus to an asynchronous parallel-bus peripheral.
// One bus access becomes BEATS device cycles with programmable setup/strobe/hold/recovery.
module parallel_dev_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEV_WIDTH      = 8,
    parameter int ADDR_WIDTH     = 2,
    parameter int SETUP_CYC      = 1,
    parameter int STROBE_CYC     = 3,
    parameter int HOLD_CYC       = 1,
    parameter int RECOVER_CYC    = 4,
    parameter int ADDR_INC       = 0,
    parameter int IRQ_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  bus_read,
    input  logic                  bus_write,
    input  logic                  bus_single,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_stall,
    output logic                  bus_irq,
    output logic                  dev_cs_n,
    output logic                  dev_rd_n,
    output logic                  dev_wr_n,
    output logic [ADDR_WIDTH-1:0] dev_addr,
    output logic [DEV_WIDTH-1:0]  dev_dout,
    output logic                  dev_oe,
    input  logic [DEV_WIDTH-1:0]  dev_din,
    input  logic                  dev_irq,
    output logic                  dev_rst_n,
    output logic [2:0]            dbg_state
);
    localparam int BEATS = DATA_WIDTH / DEV_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = 16;
    localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LAST  = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] RECOVER_LAST = CW'(RECOVER_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         beat_q, beat_d, beat_nx;
    logic                  is_read_q, is_read_d, single_q, single_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic                  cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic                  oe_q, oe_d, stall_q, stall_d;
    logic [DEV_WIDTH-1:0]  dout_q, dout_d;
    logic                  irq_meta_q, irq_sync_q;
    logic                  last, start, start_rd;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        is_read_d = is_read_q;
        single_d  = single_q;
        base_d    = base_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cs_n_d    = cs_n_q;
        rd_n_d    = rd_n_q;
        wr_n_d    = wr_n_q;
        oe_d      = oe_q;
        stall_d   = stall_q;
        dout_d    = dout_q;
        start     = 1'b0;
        start_rd  = is_read_q;
        beat_nx   = beat_q + 1'b1;
        case (state_q)
            SETUP:   last = (cnt_q == SETUP_LAST);
            STROBE:  last = (cnt_q == STROBE_LAST);
            HOLD:    last = (cnt_q == HOLD_LAST);
            RECOVER: last = (cnt_q == RECOVER_LAST);
            default: last = 1'b0;
        endcase
        cnt_d = (last || state_q == IDLE) ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (bus_read || bus_write) begin
                    is_read_d = bus_read;
                    single_d  = bus_single;
                    base_d    = bus_addr;
                    addr_d    = bus_addr;
                    wdata_d   = bus_wdata;
                    beat_d    = '0;
                    stall_d   = 1'b1;
                    cs_n_d    = 1'b0;
                    if (!bus_read) begin
                        dout_d = bus_wdata[DEV_WIDTH-1:0];
                        oe_d   = 1'b1;
                    end
                    start    = 1'b1;
                    start_rd = bus_read;
                end
            end
            SETUP: begin
                if (last) begin
                    state_d = STROBE;
                    rd_n_d  = ~is_read_q;
                    wr_n_d  = is_read_q;
                end
            end
            STROBE: begin
                if (last) begin
                    rd_n_d = 1'b1;
                    wr_n_d = 1'b1;
                    if (is_read_q) rdata_d[beat_q*DEV_WIDTH +: DEV_WIDTH] = dev_din;
                    if (HOLD_CYC > 0) begin
                        state_d = HOLD;
                    end else begin
                        state_d = RECOVER;
                        cs_n_d  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (last) begin
                    state_d = RECOVER;
                    cs_n_d  = 1'b1;
                end
            end
            RECOVER: begin
                // dev_oe survives until here so write data outlives the cs_n rising edge
                if (last) begin
                    if (beat_q < BW'(BEATS - 1) && !single_q) begin
                        beat_d = beat_nx;
                        cs_n_d = 1'b0;
                        if (ADDR_INC != 0) addr_d = base_q + ADDR_WIDTH'(beat_nx);
                        if (!is_read_q) dout_d = wdata_q[beat_nx*DEV_WIDTH +: DEV_WIDTH];
                        start = 1'b1;
                    end else begin
                        stall_d = 1'b0;
                        oe_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
            end
        endcase
        // A zero-length SETUP phase drops the strobe straight away
        if (start) begin
            if (SETUP_CYC > 0) begin
                state_d = SETUP;
            end else begin
                state_d = STROBE;
                rd_n_d  = ~start_rd;
                wr_n_d  = start_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            beat_q    <= '0;
            is_read_q <= 1'b0;
            single_q  <= 1'b0;
            base_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            oe_q      <= 1'b0;
            stall_q   <= 1'b0;
            dout_q    <= '0;
        end else if (tick) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            is_read_q <= is_read_d;
            single_q  <= single_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            oe_q      <= oe_d;
            stall_q   <= stall_d;
            dout_q    <= dout_d;
        end
    end

    // Interrupt synchroniser runs on every clk, independent of tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_meta_q <= 1'b0;
            irq_sync_q <= 1'b0;
        end else begin
            irq_meta_q <= (IRQ_ACTIVE_LOW != 0) ? ~dev_irq : dev_irq;
            irq_sync_q <= irq_meta_q;
        end
    end

    assign bus_rdata = rdata_q;
    assign bus_stall = stall_q;
    assign bus_irq   = irq_sync_q;
    assign dev_cs_n  = cs_n_q;
    assign dev_rd_n  = rd_n_q;
    assign dev_wr_n  = wr_n_q;
    assign dev_addr  = addr_q;
    assign dev_dout  = dout_q;
    assign dev_oe    = oe_q;
    assign dev_rst_n = 1'b1;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_parallel_dev_bridge.sv
// Bench for parallel_dev_bridge: a position-in-transfer model checked every clk,
// plus directed transfers with hand-computed literal expectations.
module tb_parallel_dev_bridge;
  localparam int S = 1, T = 3, H = 1, R = 4;
  localparam int P = S + T + H + R;
  localparam int BEATS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic tick_run = 1'b0;
  logic bus_read = 1'b0, bus_write = 1'b0, bus_single = 1'b0;
  logic [1:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [7:0] dev_din = '0;
  logic dev_irq = 1'b0;

  logic [31:0] bus_rdata, bus_rdata_b;
  logic bus_stall, bus_irq, dev_cs_n, dev_rd_n, dev_wr_n, dev_oe, dev_rst_n;
  logic bus_stall_b, bus_irq_b, dev_cs_n_b, dev_rd_n_b, dev_wr_n_b, dev_oe_b, dev_rst_n_b;
  logic [1:0] dev_addr, dev_addr_b;
  logic [7:0] dev_dout, dev_dout_b;
  logic [2:0] dbg_state, dbg_state_b;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic [9:0] exp_q[$];

  // model of the transfer in progress: position m_e ticks after acceptance
  logic m_active = 1'b0;
  int m_e = 0;
  int m_n = 1;
  logic m_read = 1'b0;
  logic [1:0] m_base = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;

  parallel_dev_bridge #(.DATA_WIDTH(32), .DEV_WIDTH(8), .ADDR_WIDTH(2), .SETUP_CYC(S),
    .STROBE_CYC(T), .HOLD_CYC(H), .RECOVER_CYC(R), .ADDR_INC(0), .IRQ_ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .bus_read(bus_read), .bus_write(bus_write),
    .bus_single(bus_single), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_stall(bus_stall), .bus_irq(bus_irq), .dev_cs_n(dev_cs_n), .dev_rd_n(dev_rd_n),
    .dev_wr_n(dev_wr_n), .dev_addr(dev_addr), .dev_dout(dev_dout), .dev_oe(dev_oe),
    .dev_din(dev_din), .dev_irq(dev_irq), .dev_rst_n(dev_rst_n), .dbg_state(dbg_state));

  parallel_dev_bridge #(.DATA_WIDTH(32), .DEV_WIDTH(8), .ADDR_WIDTH(2), .SETUP_CYC(S),
    .STROBE_CYC(T), .HOLD_CYC(H), .RECOVER_CYC(R), .ADDR_INC(1), .IRQ_ACTIVE_LOW(1)) u_dut_b (
    .clk(clk), .rst(rst), .tick(tick), .bus_read(bus_read), .bus_write(bus_write),
    .bus_single(bus_single), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata_b),
    .bus_stall(bus_stall_b), .bus_irq(bus_irq_b), .dev_cs_n(dev_cs_n_b), .dev_rd_n(dev_rd_n_b),
    .dev_wr_n(dev_wr_n_b), .dev_addr(dev_addr_b), .dev_dout(dev_dout_b), .dev_oe(dev_oe_b),
    .dev_din(dev_din), .dev_irq(dev_irq), .dev_rst_n(dev_rst_n_b), .dbg_state(dbg_state_b));

  // clock / tick
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      tick = tick_run ? ~tick : 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // model advance
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_active = 1'b0;
        m_e = 0;
        m_rdata = '0;
      end else if (tick) begin
        if (m_active) begin
          m_e++;
          if (m_read && (m_e % P) == S + T) m_rdata[(m_e / P) * 8 +: 8] = dev_din;
          if (m_e == m_n * P) m_active = 1'b0;
        end else if (bus_read || bus_write) begin
          m_active = 1'b1;
          m_e = 0;
          m_read = bus_read;
          m_n = bus_single ? 1 : BEATS;
          m_base = bus_addr;
          m_wdata = bus_wdata;
        end
      end
    end
  end

  // compare process
  initial begin
    int p, b;
    logic strb;
    logic [1:0] addr_inc;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        p = m_e % P;
        b = m_e / P;
        strb = m_active && p >= S && p < S + T;
        addr_inc = 2'(int'(m_base) + b);
        chk("stall", bus_stall, m_active);
        chk("stall_b", bus_stall_b, m_active);
        chk("cs_n", dev_cs_n, !(m_active && p < S + T + H));
        chk("rd_n", dev_rd_n, !(strb && m_read));
        chk("wr_n", dev_wr_n, !(strb && !m_read));
        chk("oe", dev_oe, m_active && !m_read);
        chk("rdata", bus_rdata, m_rdata);
        chk("rdata_b", bus_rdata_b, m_rdata);
        chk("rst_n", dev_rst_n, 1'b1);
        if (m_active) begin
          chk("addr", dev_addr, m_base);
          chk("addr_inc", dev_addr_b, addr_inc);
          if (!m_read) chk("dout", dev_dout, m_wdata[b * 8 +: 8]);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_tick();
    int g;
    g = 0;
    @(posedge clk);
    while (!tick && g < 50) begin
      @(posedge clk);
      g++;
    end
    if (!tick) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_txn(input logic rd, input logic wr, input logic sg, input logic [1:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rbytes,
                        input int freeze_at, input int reset_at,
                        output int stall_cnt, output int cs_cnt, output int rd_cnt, output int wr_cnt);
    int k;
    logic prev_wr;
    logic [9:0] got, want;
    stall_cnt = 0; cs_cnt = 0; rd_cnt = 0; wr_cnt = 0; prev_wr = 1'b1; k = 0;
    @(negedge clk);
    bus_read = rd; bus_write = wr; bus_single = sg; bus_addr = addr; bus_wdata = wdata;
    dev_din = rbytes[7:0];
    wait_tick();
    forever begin
      #1;
      if (!bus_stall) break;
      stall_cnt++;
      if (!dev_cs_n) cs_cnt++;
      if (!dev_rd_n) rd_cnt++;
      if (!dev_wr_n) wr_cnt++;
      if (!dev_wr_n_b && prev_wr) begin
        got = {dev_addr_b, dev_dout_b};
        if (exp_q.size() == 0) chk("beat_unexpected", {22'd0, got}, 32'd0);
        else begin
          want = exp_q.pop_front();
          chk("beat", {22'd0, got}, {22'd0, want});
        end
      end
      prev_wr = dev_wr_n_b;
      if (k == reset_at) begin
        chk("pre_rst_rd_n", dev_rd_n, 1'b0);
        rst = 1'b1; bus_read = 1'b0; bus_write = 1'b0;
        #1;
        chk("rst_cs_n", dev_cs_n, 1'b1);
        chk("rst_rd_n", dev_rd_n, 1'b1);
        chk("rst_wr_n", dev_wr_n, 1'b1);
        chk("rst_stall", bus_stall, 1'b0);
        chk("rst_oe", dev_oe, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (k == freeze_at) begin
        tick_run = 1'b0;
        repeat (10) @(posedge clk);
        tick_run = 1'b1;
      end
      dev_din = rbytes[(((k + 1) / P) % BEATS) * 8 +: 8];
      k++;
      if (k > 200) begin
        chk("stall_timeout", 32'd0, 32'd1);
        break;
      end
      wait_tick();
    end
    @(negedge clk);
    bus_read = 1'b0; bus_write = 1'b0; bus_single = 1'b0;
  endtask

  initial begin
    int sc, cc, rc, wc;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", bus_stall, 1'b0);
    chk("reset_cs_n", dev_cs_n, 1'b1);
    chk("reset_rd_n", dev_rd_n, 1'b1);
    chk("reset_wr_n", dev_wr_n, 1'b1);
    chk("reset_oe", dev_oe, 1'b0);
    chk("reset_rdata", bus_rdata, 32'h0);
    chk("reset_addr", dev_addr, 2'd0);
    chk("reset_dout", dev_dout, 8'h00);
    chk("reset_irq", bus_irq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    tick_run = 1'b1;

    // full read, four beats at a fixed address
    do_txn(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h44332211, -1, -1, sc, cc, rc, wc);
    chk("rd_stall_ticks", sc, 36);
    chk("rd_cs_low_ticks", cc, 20);
    chk("rd_strobe_ticks", rc, 12);
    chk("rd_no_wr", wc, 0);
    chk("rd_data", bus_rdata, 32'h44332211);

    // full write, incrementing address on instance b
    exp_q.push_back({2'd0, 8'hEF});
    exp_q.push_back({2'd1, 8'hBE});
    exp_q.push_back({2'd2, 8'hAD});
    exp_q.push_back({2'd3, 8'hDE});
    do_txn(1'b0, 1'b1, 1'b0, 2'd0, 32'hDEADBEEF, 32'h0, -1, -1, sc, cc, rc, wc);
    chk("wr_stall_ticks", sc, 36);
    chk("wr_strobe_ticks", wc, 12);
    chk("wr_beats_left", exp_q.size(), 0);

    // single-beat write and read
    exp_q.push_back({2'd1, 8'hA5});
    do_txn(1'b0, 1'b1, 1'b1, 2'd1, 32'h000000A5, 32'h0, -1, -1, sc, cc, rc, wc);
    chk("single_wr_stall", sc, 9);
    chk("single_wr_strobe", wc, 3);
    chk("single_wr_left", exp_q.size(), 0);
    do_txn(1'b1, 1'b0, 1'b1, 2'd3, 32'h0, 32'hFFFFFF5A, -1, -1, sc, cc, rc, wc);
    chk("single_rd_stall", sc, 9);
    chk("single_rd_data", bus_rdata, 32'h4433225A);

    // read and write together: read wins
    do_txn(1'b1, 1'b1, 1'b0, 2'd0, 32'hCAFEF00D, 32'h0D0C0B0A, -1, -1, sc, cc, rc, wc);
    chk("both_no_wr", wc, 0);
    chk("both_rd_strobe", rc, 12);
    chk("both_data", bus_rdata, 32'h0D0C0B0A);

    // reset in the second beat's strobe, then a clean read
    do_txn(1'b1, 1'b0, 1'b0, 2'd1, 32'h0, 32'h99887766, -1, 11, sc, cc, rc, wc);
    chk("post_rst_rdata", bus_rdata, 32'h0);
    repeat (3) @(negedge clk);
    do_txn(1'b1, 1'b0, 1'b0, 2'd1, 32'h0, 32'h87654321, -1, -1, sc, cc, rc, wc);
    chk("after_rst_stall", sc, 36);
    chk("after_rst_data", bus_rdata, 32'h87654321);

    // tick frozen mid-write; address wraps on instance b
    exp_q.push_back({2'd2, 8'h78});
    exp_q.push_back({2'd3, 8'h56});
    exp_q.push_back({2'd0, 8'h34});
    exp_q.push_back({2'd1, 8'h12});
    do_txn(1'b0, 1'b1, 1'b0, 2'd2, 32'h12345678, 32'h0, 7, -1, sc, cc, rc, wc);
    chk("freeze_stall", sc, 36);
    chk("freeze_beats_left", exp_q.size(), 0);

    // interrupt synchroniser with tick held low
    @(posedge clk);
    #1 tick_run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("irq_idle", bus_irq, 1'b0);
    chk("irq_b_idle", bus_irq_b, 1'b1);
    @(negedge clk);
    dev_irq = 1'b1;
    @(posedge clk);
    #1;
    chk("irq_clk1", bus_irq, 1'b0);
    @(negedge clk);
    dev_irq = 1'b0;
    @(posedge clk);
    #1;
    chk("irq_clk2", bus_irq, 1'b1);
    chk("irq_b_clk2", bus_irq_b, 1'b0);
    @(posedge clk);
    #1;
    chk("irq_clk3", bus_irq, 1'b0);
    chk("irq_b_clk3", bus_irq_b, 1'b1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/parallel_dev_bridge.md
Name: parallel_dev_bridge

Overview:
- Generalised bridge from the internal slave bus to an external asynchronous parallel-bus peripheral (USB host controller, Ethernet MAC, similar chips).
- Runs on the fast clock and advances only on `tick` (the falling-edge qualifier of the main clock).
- Splits one DATA_WIDTH bus access into DATA_WIDTH/DEV_WIDTH device beats, each with programmable setup/strobe/hold/recovery timing.
- Synchronises the device interrupt.

Parameters:
- DATA_WIDTH, 32, internal bus data width; must be a multiple of DEV_WIDTH.
- DEV_WIDTH, 8, external data bus width.
- ADDR_WIDTH, 2, external address width.
- SETUP_CYC, 1, ticks with cs_n low before the strobe (0 allowed).
- STROBE_CYC, 3, ticks with rd_n/wr_n low (≥1).
- HOLD_CYC, 1, ticks with cs_n low after the strobe (0 allowed).
- RECOVER_CYC, 4, ticks with cs_n high between beats and after the last beat (≥1).
- ADDR_INC, 0, 1 = device address increments per beat; 0 = same address every beat (FIFO port).
- IRQ_ACTIVE_LOW, 0, polarity of dev_irq.

Ports:
- clk  in  1  fast clock
- rst  in  1  reset: asynchronous, active-high
- tick  in  1  advance enable; all state frozen when 0
- bus_read  in  1  read request, held until stall falls
- bus_write  in  1  write request, held until stall falls
- bus_single  in  1  1 = transfer only beat 0 (low DEV_WIDTH bits)
- bus_addr  in  ADDR_WIDTH  device base address
- bus_wdata  in  DATA_WIDTH  write data
- bus_rdata  out  DATA_WIDTH  read data
- bus_stall  out  1  transfer in progress
- bus_irq  out  1  synchronised active-high interrupt
- dev_cs_n  out  1  chip select
- dev_rd_n  out  1  read strobe
- dev_wr_n  out  1  write strobe
- dev_addr  out  ADDR_WIDTH  device address
- dev_dout  out  DEV_WIDTH  write data
- dev_oe  out  1  tri-state enable for dev_dout
- dev_din  in  DEV_WIDTH  read data
- dev_irq  in  1  raw device interrupt
- dev_rst_n  out  1  constant 1

Behaviour:
- Reset values: dev_cs_n/rd_n/wr_n = 1; dev_oe, bus_stall, bus_rdata, dev_dout, dev_addr = 0; state IDLE; irq synchroniser cleared. Reset mid-transfer returns everything to these values immediately, with no completion.
- All register updates except the irq synchroniser happen only on clk edges with tick=1. The synchroniser runs every clk.
- States are IDLE, SETUP, STROBE, HOLD, RECOVER. A per-state counter moves to the next state on the tick where counter == N-1. States with N=0 are skipped.
- IDLE:
  - On tick with bus_read or bus_write: latch addr, wdata and single; beat = 0; bus_stall = 1; dev_cs_n = 0; dev_addr = bus_addr.
  - Read has priority if both requests are set.
  - For a write, also set dev_dout = wdata[DEV_WIDTH-1:0] and dev_oe = 1.
  - Go to SETUP.
- STROBE: the rd_n or wr_n matching the request is 0 for STROBE_CYC ticks.
  - Read: on the last STROBE tick, sample dev_din into bus_rdata[beat*DEV_WIDTH +: DEV_WIDTH] and raise the strobe.
  - Write: raise wr_n on the last STROBE tick.
- HOLD: cs_n stays 0; dev_oe and dev_dout stay stable.
- RECOVER: cs_n = 1 from the first RECOVER tick. dev_oe drops on the last RECOVER tick (write hold time).
  - On the last RECOVER tick, if another beat remains (beat < BEATS-1 and single = 0):
    - beat++ and cs_n = 0.
    - dev_addr = base + beat if ADDR_INC = 1, otherwise unchanged.
    - For a write, load the next wdata slice.
    - Go to SETUP.
  - Otherwise: bus_stall = 0, dev_oe = 0, go to IDLE.
- Latency: bus_stall is high for exactly n × (SETUP_CYC + STROBE_CYC + HOLD_CYC + RECOVER_CYC) ticks after the acceptance tick, where n = 1 if single else BEATS.
- bus_rdata holds its value until overwritten by a later read. Bytes not transferred in a single read keep their previous values.
- Requests are sampled only in IDLE. A request still asserted on the tick bus_stall falls is not re-accepted until the next IDLE tick.
- bus_irq = dev_irq (inverted if IRQ_ACTIVE_LOW) through a 2-flop synchroniser; level, not latched.

Test Plan:
- Default params, 32-bit read, tick every 2nd clk, device returns 0x11,0x22,0x33,0x44 per beat -> bus_rdata = 0x44332211; stall high for exactly 36 ticks; each cs_n-low window is 5 ticks with rd_n low for 3 ticks; dev_addr constant.
- Write 0xDEADBEEF, ADDR_INC=1, base 0 -> beats 0xEF@0, 0xBE@1, 0xAD@2, 0xDE@3; dev_oe stays high through cs_n rising; no wr_n edge while dev_oe is 0.
- bus_single=1 write 0x000000A5 -> one beat of 0xA5; stall for 9 ticks; read with single=1 updates only bits [7:0].
- bus_read and bus_write both set -> read performed; wr_n never low.
- rst asserted during the second beat's STROBE -> cs_n/rd_n/wr_n = 1, stall = 0, dev_oe = 0 at once; a new read after release completes normally.
- tick held 0 for 10 clks mid-transfer -> outputs frozen; dev_irq pulse of 1 clk → bus_irq follows 2 clks later even with tick = 0.
